// File: rtl/prio_serial_encoder.sv
// prio_serial_encoder
// Accepts an N-bit request vector over a valid/ready handshake, stores it,
// then emits the index of every set bit, one per output handshake, in
// priority order (MSB-first or LSB-first, chosen by parameter).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   request vector present
//   in_ready   block can accept a vector (IDLE)
//   in_vec     request vector, bit i = request i
//   out_valid  out_idx is valid (SCAN)
//   out_ready  consumer accepts out_idx
//   out_idx    bit position of the current highest-priority pending request
//   out_last   current out_idx is the final pending request of this vector
//   none       one-cycle pulse after a zero vector was accepted
//   busy       scanning a stored vector
module prio_serial_encoder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned IDX_W     = 3,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             none,
  output logic             busy
);

  // Elaboration guard: the index must exactly cover the vector width.
  if (IDX_W != $clog2(WIDTH) || WIDTH < 2) begin : g_bad_params
    $error("prio_serial_encoder: IDX_W must equal clog2(WIDTH) and WIDTH >= 2");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] pend_next;
  logic             none_next;
  logic [IDX_W-1:0] idx_c;
  logic             single_c;

  // Priority pick over the pending bits; the last hit in loop order wins,
  // so the loop direction selects which end has priority.
  always_comb begin
    idx_c = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (pend[i]) idx_c = IDX_W'(i);
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (pend[i]) idx_c = IDX_W'(i);
      end
    end
  end

  // Exactly one bit pending: nonzero and clearing the lowest set bit leaves zero.
  assign single_c = (pend != '0) && ((pend & (pend - WIDTH'(1))) == '0);

  // State, pending vector and zero-vector pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
      none  <= 1'b0;
    end else begin
      state <= state_next;
      pend  <= pend_next;
      none  <= none_next;
    end
  end

  // Next-state and handshake outputs; all outputs default to their idle value.
  always_comb begin
    state_next = state;
    pend_next  = pend;
    none_next  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_idx    = '0;
    out_last   = 1'b0;
    busy       = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_vec != '0) begin
            pend_next  = in_vec;
            state_next = SCAN;
          end else begin
            none_next = 1'b1;
          end
        end
      end

      SCAN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_idx   = idx_c;
        out_last  = single_c;
        if (out_ready) begin
          pend_next = pend & ~(WIDTH'(1) << idx_c);
          if (single_c) state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_prio_serial_encoder.sv
// Scoreboard bench for prio_serial_encoder: an 8-bit MSB-first instance and a
// 16-bit LSB-first instance share clock and reset. Expected {last, idx} pairs
// are queued when a vector is issued; per-instance monitors pop and compare
// on every output handshake.
module tb_prio_serial_encoder;

  logic clk = 1'b0;
  logic rst;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_none, a_busy;
  logic [7:0] a_in_vec;
  logic [2:0] a_out_idx;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_none, b_busy;
  logic [15:0] b_in_vec;
  logic [3:0]  b_out_idx;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] qa[$];
  logic [4:0] qb[$];
  logic [3:0] ea;
  logic [4:0] eb;

  prio_serial_encoder #(.WIDTH(8), .IDX_W(3), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx),
    .out_last(a_out_last), .none(a_none), .busy(a_busy)
  );

  prio_serial_encoder #(.WIDTH(16), .IDX_W(4), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
    .out_last(b_out_last), .none(b_none), .busy(b_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors sample mid-cycle; a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_unexpected: got idx %0d last %0b, expected no output", a_out_idx, a_out_last);
      end else begin
        ea = qa.pop_front();
        chk("a_idx", 32'(a_out_idx), 32'(ea[2:0]));
        chk("a_last", 32'(a_out_last), 32'(ea[3]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_unexpected: got idx %0d last %0b, expected no output", b_out_idx, b_out_last);
      end else begin
        eb = qb.pop_front();
        chk("b_idx", 32'(b_out_idx), 32'(eb[3:0]));
        chk("b_last", 32'(b_out_last), 32'(eb[4]));
      end
    end
  end

  task automatic send_a(input logic [7:0] vec);
    int n = 0;
    while (!a_in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("a_in_ready_wait", 32'(a_in_ready), 32'd1);
    a_in_vec   = vec;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_vec   = '0;
  endtask

  task automatic send_b(input logic [15:0] vec);
    int n = 0;
    while (!b_in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("b_in_ready_wait", 32'(b_in_ready), 32'd1);
    b_in_vec   = vec;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_in_vec   = '0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (qa.size() != 0 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("a_drain", 32'(qa.size()), 32'd0);
  endtask

  task automatic drain_b();
    int n = 0;
    while (qb.size() != 0 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("b_drain", 32'(qb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_vec = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_vec = '0; b_out_ready = 1'b0;

    // Reset released mid-cycle
    #23 rst = 1'b0;
    #1;
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_out_idx",   32'(a_out_idx),   32'd0);
    chk("rst_a_out_last",  32'(a_out_last),  32'd0);
    chk("rst_a_none",      32'(a_none),      32'd0);
    chk("rst_a_busy",      32'(a_busy),      32'd0);
    chk("rst_a_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    chk("rst_b_in_ready",  32'(b_in_ready),  32'd1);
    @(posedge clk); #1;

    // MSB-first drain of 1010_0100: 7, 5, 2(last)
    a_out_ready = 1'b1;
    qa.push_back({1'b0, 3'd7});
    qa.push_back({1'b0, 3'd5});
    qa.push_back({1'b1, 3'd2});
    send_a(8'hA4);
    chk("t1_out_valid", 32'(a_out_valid), 32'd1);
    chk("t1_busy",      32'(a_busy),      32'd1);
    chk("t1_in_ready",  32'(a_in_ready),  32'd0);
    drain_a();
    chk("t1_in_ready_after", 32'(a_in_ready),  32'd1);
    chk("t1_valid_after",    32'(a_out_valid), 32'd0);

    // Back-pressure on 8'h81: idx 7 held for 3 cycles, then 7, 0(last)
    a_out_ready = 1'b0;
    qa.push_back({1'b0, 3'd7});
    qa.push_back({1'b1, 3'd0});
    send_a(8'h81);
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_valid", 32'(a_out_valid), 32'd1);
      chk("t2_hold_idx",   32'(a_out_idx),   32'd7);
      chk("t2_hold_last",  32'(a_out_last),  32'd0);
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    drain_a();
    chk("t2_in_ready_after", 32'(a_in_ready), 32'd1);

    // Zero vector: one-cycle none pulse, no output
    send_a(8'h00);
    chk("t3_none",      32'(a_none),      32'd1);
    chk("t3_out_valid", 32'(a_out_valid), 32'd0);
    chk("t3_in_ready",  32'(a_in_ready),  32'd1);
    @(posedge clk); #1;
    chk("t3_none_gone",  32'(a_none),      32'd0);
    chk("t3_out_valid2", 32'(a_out_valid), 32'd0);

    // New vector offered while scanning is ignored
    a_out_ready = 1'b0;
    qa.push_back({1'b0, 3'd6});
    qa.push_back({1'b1, 3'd3});
    send_a(8'h48);
    a_in_vec   = 8'h40;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_vec   = '0;
    chk("t4_busy", 32'(a_busy),    32'd1);
    chk("t4_idx",  32'(a_out_idx), 32'd6);
    a_out_ready = 1'b1;
    drain_a();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t4_no_residue", 32'(a_out_valid), 32'd0);

    // Asynchronous reset after two handshakes of 8'hFF
    qa.push_back({1'b0, 3'd7});
    qa.push_back({1'b0, 3'd6});
    send_a(8'hFF);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_valid",    32'(a_out_valid), 32'd0);
    chk("t5_rst_busy",     32'(a_busy),      32'd0);
    chk("t5_rst_idx",      32'(a_out_idx),   32'd0);
    chk("t5_rst_last",     32'(a_out_last),  32'd0);
    chk("t5_rst_in_ready", 32'(a_in_ready),  32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t5_rel_valid", 32'(a_out_valid), 32'd0);
    chk("t5_queue",     32'(qa.size()),   32'd0);
    qa.push_back({1'b1, 3'd3});
    send_a(8'h08);
    chk("t5_new_idx",  32'(a_out_idx),  32'd3);
    chk("t5_new_last", 32'(a_out_last), 32'd1);
    drain_a();
    chk("t5_in_ready_after", 32'(a_in_ready), 32'd1);

    // 16-bit LSB-first: 8001 -> 0, 15(last); 0010 -> 4(last) immediately
    b_out_ready = 1'b1;
    qb.push_back({1'b0, 4'd0});
    qb.push_back({1'b1, 4'd15});
    send_b(16'h8001);
    drain_b();
    chk("b1_in_ready_after", 32'(b_in_ready), 32'd1);
    b_out_ready = 1'b0;
    qb.push_back({1'b1, 4'd4});
    send_b(16'h0010);
    chk("b2_idx",  32'(b_out_idx),  32'd4);
    chk("b2_last", 32'(b_out_last), 32'd1);
    b_out_ready = 1'b1;
    drain_b();
    chk("b2_in_ready_after", 32'(b_in_ready), 32'd1);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
